mux41_rr_tx: RTL and testbench

Four-channel round-robin multiplexer that merges four valid/ready sources onto one output stream, tagging each word with a 2-bit channel select. It is the transmit end of the 1-to-4 select/data link: its `y`/`s` pair drives a downstream 1x4 demultiplexer, which routes `y` to output `s`. A single registered output slot decouples the arbiter from downstream backpressure.

---
 rtl/mux41_rr_tx.sv | 85 ++++++++
 tb/tb_mux41_rr_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux41_rr_tx.sv
// mux41_rr_tx: four-channel round-robin merge onto one registered output
// slot. Each word is tagged with its source channel in s, so a downstream
// 1x4 demux can route y back out to the matching port.
module mux41_rr_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  output logic             r0,
  output logic             r1,
  output logic             r2,
  output logic             r3,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       s,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0]            vld;
  logic [NUM_CH-1:0][WIDTH-1:0] dat;
  logic [NUM_CH-1:0]            rdy;
  logic [1:0]                   ptr;
  logic                         load_en;
  logic                         gnt_any;
  logic [1:0]                   gnt_idx;
  logic [1:0]                   idx;

  assign vld = {v3, v2, v1, v0};
  assign dat = {d3, d2, d1, d0};

  // The slot can take a new word when empty or when its current word drains
  // this cycle, so drain and refill share one edge with no bubble.
  assign load_en = !y_valid || y_ready;

  // Search from the pointer upward (mod 4); first valid channel wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    idx     = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_any && vld[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // One-hot ready; held low during reset so no source sees a phantom accept.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_rdy
    assign rdy[k] = rst_n && load_en && gnt_any && (gnt_idx == 2'(k));
  end

  assign {r3, r2, r1, r0} = rdy;

  // Output slot and pointer; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      s       <= 2'b00;
      y_valid <= 1'b0;
      ptr     <= 2'b00;
    end else if (load_en) begin
      if (gnt_any) begin
        y       <= dat[gnt_idx];
        s       <= gnt_idx;
        y_valid <= 1'b1;
        ptr     <= gnt_idx + 2'd1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux41_rr_tx.sv
// Testbench for mux41_rr_tx: directed vectors push expected {s,y} words into
// a scoreboard queue; a monitor pops and compares on every output transfer.
module tb_mux41_rr_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1, d2, d3;
  logic       v0, v1, v2, v3;
  logic       r0, r1, r2, r3;
  logic [7:0] y;
  logic [1:0] s;
  logic       y_valid;
  logic       y_ready;

  int n_chk  = 0;
  int n_fail = 0;
  logic [9:0] sb[$];

  mux41_rr_tx #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .y(y), .s(s), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setv(input logic [3:0] v);
    {v3, v2, v1, v0} = v;
  endtask

  // Check the ready vector for the current inputs, record the expected word
  // if one is accepted, then advance to just after the next rising edge.
  task automatic step(input logic [3:0] exp_r, input logic [1:0] exp_s, input logic [7:0] exp_y);
    #1;
    chk("ready", {r3, r2, r1, r0}, exp_r);
    if (exp_r != 4'b0000) sb.push_back({exp_s, exp_y});
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change just after rising edges, so at the falling edge
  // y_valid && y_ready marks a transfer at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && y_valid && y_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {s, y}, 10'h3ff);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          chk("out_s", s, e[9:8]);
          chk("out_y", y, e[7:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; y_ready = 1'b1;
    d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
    setv(4'b1111);
    #12;
    chk("rst_y", y, 8'h00);
    chk("rst_s", s, 2'b00);
    chk("rst_valid", y_valid, 1'b0);
    chk("rst_ready", {r3, r2, r1, r0}, 4'b0000);

    // Release between edges; channel 0 wins first.
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 2'd0, 8'hA0);
    chk("first_valid", y_valid, 1'b1);
    chk("first_y", y, 8'hA0);

    // Full contention: rotate 1,2,3,0,1,2,3.
    step(4'b0010, 2'd1, 8'hA1);
    step(4'b0100, 2'd2, 8'hA2);
    step(4'b1000, 2'd3, 8'hA3);
    step(4'b0001, 2'd0, 8'hA0);
    step(4'b0010, 2'd1, 8'hA1);
    step(4'b0100, 2'd2, 8'hA2);
    step(4'b1000, 2'd3, 8'hA3);

    // Pointer skip and wrap: ch2, then only ch0/ch3 -> ch3 then ch0.
    setv(4'b0100);
    step(4'b0100, 2'd2, 8'hA2);
    setv(4'b1001);
    step(4'b1000, 2'd3, 8'hA3);
    step(4'b0001, 2'd0, 8'hA0);

    // Backpressure: load 5A from ch1, stall 3 cycles, then refill from ch2.
    d1 = 8'h5A;
    setv(4'b0010);
    step(4'b0010, 2'd1, 8'h5A);
    y_ready = 1'b0;
    setv(4'b1111);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 2'd0, 8'h00);
      chk("stall_y", y, 8'h5A);
      chk("stall_s", s, 2'b01);
      chk("stall_valid", y_valid, 1'b1);
    end
    y_ready = 1'b1;
    step(4'b0100, 2'd2, 8'hA2);
    chk("refill_s", s, 2'b10);

    // Idle drain: single word from ch1 then nothing.
    d1 = 8'h3C;
    setv(4'b0010);
    step(4'b0010, 2'd1, 8'h3C);
    setv(4'b0000);
    step(4'b0000, 2'd0, 8'h00);
    chk("drain_valid", y_valid, 1'b0);
    chk("drain_y", y, 8'h3C);
    chk("drain_s", s, 2'b01);

    // Reset mid-stall: word from ch0 (ptr=2 -> 2,3,0), stall, async reset.
    setv(4'b0001);
    step(4'b0001, 2'd0, 8'hA0);
    y_ready = 1'b0;
    setv(4'b1111);
    step(4'b0000, 2'd0, 8'h00);
    chk("pre_rst_valid", y_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 8'h00);
    chk("async_rst_s", s, 2'b00);
    chk("async_rst_valid", y_valid, 1'b0);
    chk("async_rst_ready", {r3, r2, r1, r0}, 4'b0000);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    y_ready = 1'b1;
    step(4'b0001, 2'd0, 8'hA0);
    setv(4'b0000);
    step(4'b0000, 2'd0, 8'h00);
    step(4'b0000, 2'd0, 8'h00);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
